// File: rtl/video_stream_tx.sv
// video_stream_tx
// Head-of-pipeline video transmitter. Pulls pixels from an upstream source
// over a valid/ready handshake and emits a registered pixel/sync/valid raster
// stream whose timing comes from the porch/sync parameters.
//
// Ports:
//   iClk, iRst_n       clock, asynchronous active-low reset
//   iEnable            run request, acted on only at frame boundaries
//   iPix, iPixValid    upstream pixel and its valid
//   oPixReady          combinational; high only on active pixels while running
//   iClrErr            clears the sticky underflow flag (a new underflow wins)
//   oPix               output pixel (0 outside active pixels and on underflow)
//   oHSync, oVSync     active-high syncs
//   oLineValid         active pixel in an active line
//   oFrameValid        active-line region of the frame
//   oUnderflow         sticky: an active pixel was due but iPixValid was low
//
// Optional build macro VIDEO_STREAM_TX_PATTERN_EN adds iPatternMode. When the
// mode is latched high at a frame boundary the source is not pulled and active
// pixels carry h XOR v instead.
//
// State | Meaning
// IDLE  | counters held at 0, stream outputs driven to 0, waiting for iEnable
// RUN   | raster counters advance every cycle; exit only at end of frame
module video_stream_tx #(
  parameter int PIX_WIDTH = 8,
  parameter int H_ACTIVE  = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 21
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic [PIX_WIDTH-1:0] iPix,
  input  logic                 iPixValid,
  output logic                 oPixReady,
  input  logic                 iClrErr,
`ifdef VIDEO_STREAM_TX_PATTERN_EN
  input  logic                 iPatternMode,
`endif
  output logic [PIX_WIDTH-1:0] oPix,
  output logic                 oHSync,
  output logic                 oVSync,
  output logic                 oLineValid,
  output logic                 oFrameValid,
  output logic                 oUnderflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  typedef enum logic {IDLE, RUN} stateT;

  stateT          state, stateNext;
  logic [HW-1:0]  cntH;
  logic [VW-1:0]  cntV;
  int             posH, posV;
  logic           lastH, lastV;
  logic           active, hsDec, vsDec, frameDec;

  logic [PIX_WIDTH-1:0] pixNext;
  logic                 lvNext, hsNext, vsNext, fvNext, ufSet;

  assign posH     = int'(cntH);
  assign posV     = int'(cntV);
  assign lastH    = (posH == H_TOTAL - 1);
  assign lastV    = (posV == V_TOTAL - 1);
  assign active   = (posH < H_ACTIVE) && (posV < V_ACTIVE);
  assign hsDec    = (posH >= H_ACTIVE + H_FRONT) && (posH < H_ACTIVE + H_FRONT + H_SYNC);
  assign vsDec    = (posV >= V_ACTIVE + V_FRONT) && (posV < V_ACTIVE + V_FRONT + V_SYNC);
  assign frameDec = (posV < V_ACTIVE);

`ifdef VIDEO_STREAM_TX_PATTERN_EN
  logic                 patternMode;
  logic [PIX_WIDTH-1:0] patPix;

  // Zero-extend before slicing so narrow counters still produce PIX_WIDTH bits.
  assign patPix = PIX_WIDTH'(32'(cntH) ^ 32'(cntV));

  // Latched only while idle or on the last cycle of a frame, so a frame is
  // never split between source pixels and pattern pixels.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      patternMode <= 1'b0;
    end else if (state == IDLE || (lastH && lastV)) begin
      patternMode <= iPatternMode;
    end
  end
`endif

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: leaving RUN is only allowed on the final frame cycle.
  always_comb begin
    stateNext = state;
    if (state == IDLE) begin
      if (iEnable) stateNext = RUN;
    end else begin
      if (lastH && lastV && !iEnable) stateNext = IDLE;
    end
  end

  // Output decode: ready and the next values of the registered stream.
  always_comb begin
    oPixReady = 1'b0;
    pixNext   = '0;
    lvNext    = 1'b0;
    hsNext    = 1'b0;
    vsNext    = 1'b0;
    fvNext    = 1'b0;
    ufSet     = 1'b0;
    if (state == RUN) begin
      lvNext = active;
      hsNext = hsDec;
      vsNext = vsDec;
      fvNext = frameDec;
      if (active) begin
`ifdef VIDEO_STREAM_TX_PATTERN_EN
        if (patternMode) begin
          pixNext = patPix;
        end else begin
          oPixReady = 1'b1;
          pixNext   = iPixValid ? iPix : '0;
          ufSet     = !iPixValid;
        end
`else
        oPixReady = 1'b1;
        pixNext   = iPixValid ? iPix : '0;
        ufSet     = !iPixValid;
`endif
      end
    end
  end

  // Raster counters; an underflow never stalls them.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cntH <= '0;
      cntV <= '0;
    end else if (state == IDLE) begin
      cntH <= '0;
      cntV <= '0;
    end else if (lastH) begin
      cntH <= '0;
      cntV <= lastV ? '0 : cntV + 1'b1;
    end else begin
      cntH <= cntH + 1'b1;
    end
  end

  // Registered stream outputs, one cycle behind the counter decode.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPix        <= '0;
      oHSync      <= 1'b0;
      oVSync      <= 1'b0;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
      oUnderflow  <= 1'b0;
    end else begin
      oPix        <= pixNext;
      oHSync      <= hsNext;
      oVSync      <= vsNext;
      oLineValid  <= lvNext;
      oFrameValid <= fvNext;
      if (ufSet) begin
        oUnderflow <= 1'b1;
      end else if (iClrErr) begin
        oUnderflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_tx.sv
module tb_video_stream_tx;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iEnable;
  logic [7:0] iPix;
  logic       iPixValid;
  logic       oPixReady;
  logic       iClrErr;
`ifdef VIDEO_STREAM_TX_PATTERN_EN
  logic       iPatternMode;
`endif
  logic [7:0] oPix;
  logic       oHSync, oVSync, oLineValid, oFrameValid, oUnderflow;

  video_stream_tx #(
    .PIX_WIDTH(8),
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iEnable(iEnable),
    .iPix(iPix),
    .iPixValid(iPixValid),
    .oPixReady(oPixReady),
    .iClrErr(iClrErr),
`ifdef VIDEO_STREAM_TX_PATTERN_EN
    .iPatternMode(iPatternMode),
`endif
    .oPix(oPix),
    .oHSync(oHSync),
    .oVSync(oVSync),
    .oLineValid(oLineValid),
    .oFrameValid(oFrameValid),
    .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  // flags order: lineValid, hSync, vSync, frameValid, pixReady, underflow
  typedef struct {
    int         idx;
    logic [7:0] pix;
    logic [5:0] flags;
  } vecT;

  vecT vecs[48];
  int  nApplied = 0;
  int  nMiss = 0;
  logic [7:0] srcPix = 8'h10;

  logic [7:0] capPix[48];
  logic [5:0] capFlags[48];
  logic       capRdy[48];

  function automatic vecT mk(input int idx, input logic [7:0] pix, input logic [5:0] flags);
    vecT v;
    v.idx = idx;
    v.pix = pix;
    v.flags = flags;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Source model: a pixel is consumed when ready and valid were both high at the edge.
  task automatic tick();
    logic took;
    took = oPixReady && iPixValid;
    @(posedge iClk);
    #1;
    if (took) srcPix = srcPix + 8'd1;
    iPix = srcPix;
  endtask

  // Starts at raster index 0 (just after an edge) and runs n cycles,
  // capturing the registered outputs belonging to each raster index.
  task automatic runIdx(input int n, input int dropIdx, input int clrA, input int clrB,
                        input int enOffIdx, input logic baseValid);
    for (int j = 0; j < n; j++) begin
      iPixValid = (j == dropIdx) ? 1'b0 : baseValid;
      iClrErr   = (j == clrA) || (j == clrB);
      if (j == enOffIdx) iEnable = 1'b0;
      capRdy[j] = oPixReady;
      tick();
      capPix[j]   = oPix;
      capFlags[j] = {oLineValid, oHSync, oVSync, oFrameValid, 1'b0, oUnderflow};
    end
    iPixValid = 1'b1;
    iClrErr   = 1'b0;
  endtask

  task automatic checkGroup(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int k;
      logic [13:0] got, exp;
      k = vecs[i].idx;
      got = {capPix[k], capFlags[k][5:2], capRdy[k], capFlags[k][0]};
      exp = {vecs[i].pix, vecs[i].flags};
      nApplied++;
      if (got !== exp) begin
        nMiss++;
        $display("FAIL %s vec%0d idx%0d: got pix=%02h lv/hs/vs/fv/rdy/uf=%06b, expected pix=%02h %06b",
                 tag, i, k, got[13:6], got[5:0], exp[13:6], exp[5:0]);
      end
    end
  endtask

  initial begin
    int n;
    // frame 1: continuous source from 0x10
    vecs[0]  = mk(0,  8'h10, 6'b100110);
    vecs[1]  = mk(3,  8'h13, 6'b100110);
    vecs[2]  = mk(4,  8'h00, 6'b000100);
    vecs[3]  = mk(5,  8'h00, 6'b010100);
    vecs[4]  = mk(6,  8'h00, 6'b010100);
    vecs[5]  = mk(7,  8'h00, 6'b000100);
    vecs[6]  = mk(8,  8'h14, 6'b100110);
    vecs[7]  = mk(19, 8'h1B, 6'b100110);
    vecs[8]  = mk(21, 8'h00, 6'b010100);
    vecs[9]  = mk(24, 8'h00, 6'b000000);
    vecs[10] = mk(29, 8'h00, 6'b010000);
    vecs[11] = mk(32, 8'h00, 6'b001000);
    vecs[12] = mk(37, 8'h00, 6'b011000);
    vecs[13] = mk(39, 8'h00, 6'b001000);
    vecs[14] = mk(40, 8'h00, 6'b000000);
    vecs[15] = mk(47, 8'h00, 6'b000000);
    // frame 2: valid dropped at idx 9, clear at idx 30
    vecs[16] = mk(8,  8'h20, 6'b100110);
    vecs[17] = mk(9,  8'h00, 6'b100111);
    vecs[18] = mk(10, 8'h21, 6'b100111);
    vecs[19] = mk(11, 8'h22, 6'b100111);
    vecs[20] = mk(16, 8'h23, 6'b100111);
    vecs[21] = mk(19, 8'h26, 6'b100111);
    vecs[22] = mk(29, 8'h00, 6'b010001);
    vecs[23] = mk(30, 8'h00, 6'b010000);
    vecs[24] = mk(47, 8'h00, 6'b000000);
    // frame 3: drop and clear together at idx 1, clear at 20, enable off at 8
    vecs[25] = mk(0,  8'h27, 6'b100110);
    vecs[26] = mk(1,  8'h00, 6'b100111);
    vecs[27] = mk(2,  8'h28, 6'b100111);
    vecs[28] = mk(16, 8'h2E, 6'b100111);
    vecs[29] = mk(20, 8'h00, 6'b000100);
    vecs[30] = mk(37, 8'h00, 6'b011000);
    vecs[31] = mk(47, 8'h00, 6'b000000);
    // frame 4 after idle, frame 5 after mid-line reset
    vecs[32] = mk(0,  8'h32, 6'b100110);
    vecs[33] = mk(5,  8'h00, 6'b010100);
    vecs[34] = mk(8,  8'h36, 6'b100110);
    vecs[35] = mk(9,  8'h37, 6'b100110);
    vecs[36] = mk(0,  8'h38, 6'b100110);
    vecs[37] = mk(5,  8'h00, 6'b010100);
    vecs[38] = mk(8,  8'h3C, 6'b100110);
    // pattern mode: h ^ v
    vecs[39] = mk(1,  8'h01, 6'b100100);
    vecs[40] = mk(10, 8'h03, 6'b100100);
    vecs[41] = mk(16, 8'h02, 6'b100100);
    vecs[42] = mk(17, 8'h03, 6'b100100);
    vecs[43] = mk(18, 8'h00, 6'b100100);
    vecs[44] = mk(19, 8'h01, 6'b100100);
    vecs[45] = mk(20, 8'h00, 6'b000100);

    iRst_n = 1'b0; iEnable = 1'b0; iPix = srcPix; iPixValid = 1'b1; iClrErr = 1'b0;
`ifdef VIDEO_STREAM_TX_PATTERN_EN
    iPatternMode = 1'b0;
`endif
    repeat (2) @(posedge iClk);
    #1;
    chk("reset outputs", {oPix, oLineValid, oHSync, oVSync, oFrameValid, oPixReady, oUnderflow}, 0);
    #2 iRst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle ready", oPixReady, 0);
      chk("idle outputs", {oPix, oLineValid, oHSync, oVSync, oFrameValid}, 0);
    end

    // frame 1
    iEnable = 1'b1;
    tick();
    runIdx(48, -1, -1, -1, -1, 1'b1);
    checkGroup("frame1", 0, 15);
    begin
      int cLv, cHs, cVs, cFv, cRdy;
      cLv = 0; cHs = 0; cVs = 0; cFv = 0; cRdy = 0; n = 0;
      for (int j = 0; j < 48; j++) begin
        cLv += int'(capFlags[j][5]);
        cHs += int'(capFlags[j][4]);
        cVs += int'(capFlags[j][3]);
        cFv += int'(capFlags[j][2]);
        cRdy += int'(capRdy[j]);
        if (capFlags[j][5]) begin
          chk("frame1 pixel order", capPix[j], 32'h10 + n);
          n++;
        end
      end
      chk("frame1 lineValid count", cLv, 12);
      chk("frame1 hSync count", cHs, 12);
      chk("frame1 vSync count", cVs, 8);
      chk("frame1 frameValid count", cFv, 24);
      chk("frame1 ready count", cRdy, 12);
    end

    // frame 2: underflow, no stall, sticky, cleared
    runIdx(48, 9, 30, -1, -1, 1'b1);
    checkGroup("frame2", 16, 24);

    // frame 3: set beats clear, enable dropped on line 1
    runIdx(48, 1, 1, 20, 8, 1'b1);
    checkGroup("frame3", 25, 31);
    chk("idle entry ready", oPixReady, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle hold ready", oPixReady, 0);
    end
    chk("idle hold outputs", {oPix, oLineValid, oHSync, oVSync, oFrameValid, oUnderflow}, 0);

    // frame 4: restart, then async reset at h=2, v=1
    iEnable = 1'b1;
    tick();
    runIdx(10, -1, -1, -1, -1, 1'b1);
    checkGroup("frame4", 32, 35);
    #2 iRst_n = 1'b0;
    #1;
    chk("async reset outputs", {oPix, oLineValid, oHSync, oVSync, oFrameValid, oPixReady, oUnderflow}, 0);
    #3 iRst_n = 1'b1;
    tick();
    runIdx(10, -1, -1, -1, -1, 1'b1);
    checkGroup("frame5", 36, 38);

`ifdef VIDEO_STREAM_TX_PATTERN_EN
    #2 iRst_n = 1'b0;
    iPatternMode = 1'b1;
    #2 iRst_n = 1'b1;
    tick();
    runIdx(24, -1, -1, -1, -1, 1'b0);
    checkGroup("pattern", 39, 45);
    n = 0;
    for (int j = 0; j < 24; j++) n += int'(capRdy[j]);
    chk("pattern ready count", n, 0);
    chk("pattern underflow", oUnderflow, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
